// File: rtl/comp_divider.sv
// comp_divider: 32-bit unsigned restoring shift-subtract divider with a Run/Ready handshake.
module comp_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Ready
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   trial;
  logic             last;
  // rem stays below the divisor, so its top bit is always clear before the shift
  always_comb begin
    sh      = {rem[WIDTH-1:0], dq[WIDTH-1]};
    trial   = sh - {1'b0, dvs};
    last    = cnt == CW'(WIDTH);
    state_n = state;
    case (state)
      IDLE:    state_n = Run ? BUSY : IDLE;
      BUSY:    state_n = last ? DONE : BUSY;
      DONE:    state_n = Run ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) state <= IDLE;
    else        state <= state_n;
  // dq carries the dividend in and shifts the quotient bits in behind it
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) begin
      rem       <= '0;
      dq        <= '0;
      dvs       <= '0;
      cnt       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      Ready     <= 1'b0;
    end else if (state == IDLE) begin
      Ready <= 1'b0;
      if (Run) begin
        rem <= '0;
        dq  <= Dividend;
        dvs <= Divisor;
        cnt <= '0;
      end
    end else if (state == BUSY) begin
      if (last) begin
        Quotient  <= dq;
        Remainder <= rem[WIDTH-1:0];
        Ready     <= 1'b1;
      end else begin
        rem <= trial[WIDTH] ? sh : trial;
        dq  <= {dq[WIDTH-2:0], ~trial[WIDTH]};
        cnt <= cnt + 1'b1;
      end
    end else begin
      Ready <= Run;
    end
endmodule

// File: tb/tb_comp_divider.sv
// tb_comp_divider: randomized and directed checks of comp_divider against plain-arithmetic division.
module tb_comp_divider;
  logic        clk = 0;
  logic        Reset = 0;
  logic        Run = 0;
  logic [31:0] Dividend = 0;
  logic [31:0] Divisor = 0;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        Ready;
  int vectors = 0;
  int errors = 0;

  comp_divider dut (
    .clk(clk), .Reset(Reset), .Run(Run), .Dividend(Dividend), .Divisor(Divisor),
    .Quotient(Quotient), .Remainder(Remainder), .Ready(Ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_q(input logic [31:0] a, input logic [31:0] b);
    return (b == 0) ? 32'hFFFF_FFFF : a / b;
  endfunction

  function automatic logic [31:0] exp_r(input logic [31:0] a, input logic [31:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  // Launch one division, scramble the operand inputs while busy, and count edges until Ready.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, output int n);
    Dividend = a;
    Divisor = b;
    Run = 1;
    @(posedge clk); #1;
    Dividend = $urandom;
    Divisor = $urandom;
    n = 0;
    while (!Ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic release_run();
    Run = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (Ready !== 1'b0 || Quotient !== 0 || Remainder !== 0) begin
      errors++;
      $display("FAIL reset: Ready=%b Q=%h R=%h, required 0 0 0", Ready, Quotient, Remainder);
    end
    #20 Reset = 1;
    @(posedge clk); #1;
    vectors++;
    if (Ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: Ready=%b, required 0", Ready);
    end
  endtask

  task automatic test_basic();
    int n;
    run_div(32'd100, 32'd7, n);
    vectors++;
    if (n !== 33) begin errors++; $display("FAIL basic_latency: %0d edges, required 33", n); end
    vectors++;
    if (Quotient !== 32'hE || Remainder !== 32'h2) begin
      errors++;
      $display("FAIL basic_result: Q=%h R=%h, required 0000000e 00000002", Quotient, Remainder);
    end
    release_run();
  endtask

  task automatic test_directed();
    logic [31:0] a [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd1234, 32'h8000_0000};
    logic [31:0] b [6] = '{32'h1, 32'hFFFF_FFFF, 32'd10, 32'd3, 32'd0, 32'hFFFF_FFFF};
    int n;
    for (int i = 0; i < 6; i++) begin
      run_div(a[i], b[i], n);
      vectors++;
      if (n !== 33) begin errors++; $display("FAIL dir%0d_latency: %0d edges, required 33", i, n); end
      vectors++;
      if (Quotient !== exp_q(a[i], b[i]) || Remainder !== exp_r(a[i], b[i])) begin
        errors++;
        $display("FAIL dir%0d_result: %h/%h Q=%h R=%h, required %h %h", i, a[i], b[i],
                 Quotient, Remainder, exp_q(a[i], b[i]), exp_r(a[i], b[i]));
      end
      release_run();
      vectors++;
      if (Ready !== 1'b0 || Quotient !== exp_q(a[i], b[i])) begin
        errors++;
        $display("FAIL dir%0d_release: Ready=%b Q=%h, required 0 %h", i, Ready, Quotient, exp_q(a[i], b[i]));
      end
    end
  endtask

  task automatic test_abort();
    int n;
    Dividend = 32'd1000;
    Divisor = 32'd3;
    Run = 1;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #2 Reset = 0;
    #1;
    vectors++;
    if (Ready !== 1'b0 || Quotient !== 0 || Remainder !== 0) begin
      errors++;
      $display("FAIL abort: Ready=%b Q=%h R=%h, required 0 0 0", Ready, Quotient, Remainder);
    end
    Run = 0;
    @(posedge clk); #2;
    Reset = 1;
    @(posedge clk); #1;
    vectors++;
    if (Ready !== 1'b0) begin errors++; $display("FAIL abort_idle: Ready=%b, required 0", Ready); end
    run_div(32'd1000, 32'd3, n);
    vectors++;
    if (n !== 33 || Quotient !== 32'd333 || Remainder !== 32'd1) begin
      errors++;
      $display("FAIL abort_restart: edges=%0d Q=%0d R=%0d, required 33 333 1", n, Quotient, Remainder);
    end
    release_run();
  endtask

  task automatic test_hold();
    int n;
    logic [31:0] a = 32'd98765;
    logic [31:0] b = 32'd123;
    run_div(a, b, n);
    repeat (5) begin
      Dividend = $urandom;
      Divisor = $urandom;
      @(posedge clk); #1;
    end
    vectors++;
    if (Ready !== 1'b1 || Quotient !== a / b || Remainder !== a % b) begin
      errors++;
      $display("FAIL hold: Ready=%b Q=%0d R=%0d, required 1 %0d %0d", Ready, Quotient, Remainder, a / b, a % b);
    end
    release_run();
    vectors++;
    if (Ready !== 1'b0 || Quotient !== a / b || Remainder !== a % b) begin
      errors++;
      $display("FAIL hold_release: Ready=%b Q=%0d R=%0d, required 0 %0d %0d", Ready, Quotient, Remainder, a / b, a % b);
    end
    run_div(32'd77777, 32'd11, n);
    vectors++;
    if (n !== 33 || Quotient !== 32'd7070 || Remainder !== 32'd7) begin
      errors++;
      $display("FAIL hold_restart: edges=%0d Q=%0d R=%0d, required 33 7070 7", n, Quotient, Remainder);
    end
    release_run();
  endtask

  task automatic test_random();
    int n;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : (i % 3 == 1) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
      run_div(a, b, n);
      vectors++;
      if (n !== 33 || Quotient !== exp_q(a, b) || Remainder !== exp_r(a, b)) begin
        errors++;
        $display("FAIL rand%0d: %h/%h edges=%0d Q=%h R=%h, required 33 %h %h", i, a, b, n,
                 Quotient, Remainder, exp_q(a, b), exp_r(a, b));
      end
      if (b != 0) begin
        vectors++;
        if (64'(Quotient) * 64'(b) + 64'(Remainder) !== 64'(a) || Remainder >= b) begin
          errors++;
          $display("FAIL rand%0d_invariant: Q*b+R=%h R=%h, required %h and R<%h", i,
                   64'(Quotient) * 64'(b) + 64'(Remainder), Remainder, a, b);
        end
      end
      release_run();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_abort();
    test_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
